// File: rtl/uart_send_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO with a valid/ready push port,
// drained LSB-first onto uart_tx. Frames go back-to-back while data remains.
module uart_send_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        send_data,
    input  logic              send_valid,
    output logic              send_ready,
    output logic              uart_tx,
    output logic              uart_busy,
    output logic [ADDR_W:0]   fifo_level
);

    localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic timer_done;

    assign send_ready = (level_q != LVL_FULL);
    assign push       = send_valid & send_ready;
    assign timer_done = (timer_q == TMR_LAST);

    assign uart_tx    = tx_q;
    assign uart_busy  = (state_q != IDLE) || (level_q != '0);
    assign fifo_level = level_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // The FSM only looks at the registered level, so a push into an empty
    // FIFO is seen one edge later rather than bypassed into the shifter.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (timer_done) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DATA: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (bit_idx_q != 3'd7) begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            STOP: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    // Storage is data-only; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= send_data;
        end
    end

endmodule

// File: tb/tb_uart_send_fifo.sv
// Directed bench for uart_send_fifo: table of single frames plus hand-written
// back-to-back, fill/full, pointer-wrap and mid-frame reset sequences.
module tb_uart_send_fifo;

    localparam int CPB   = 6;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int FRAME = 10 * CPB;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    send_data = 8'h00;
    logic          send_valid = 1'b0;
    logic          send_ready;
    logic          uart_tx;
    logic          uart_busy;
    logic [AW:0]   fifo_level;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_send_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_W      (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .send_data (send_data),
        .send_valid(send_valid),
        .send_ready(send_ready),
        .uart_tx   (uart_tx),
        .uart_busy (uart_busy),
        .fifo_level(fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        while (uart_busy !== 1'b0 && n < max_cycles) begin
            step();
            n++;
        end
        check(name, {31'd0, uart_busy}, 32'd0);
        repeat (3) step();
    endtask

    // Independent line decoder: mid-bit sampling, records byte and start cycle.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         mon_act = 1'b0;
    int         mon_cnt, mon_t0, mon_k;
    logic [7:0] mon_sh;

    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (uart_tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                mon_t0  = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                mon_k = mon_cnt / CPB;
                if (mon_k == 0) begin
                    check("mon_start_bit", {31'd0, uart_tx}, 32'd0);
                end else if (mon_k <= 8) begin
                    mon_sh[mon_k-1] = uart_tx;
                end else begin
                    check("mon_stop_bit", {31'd0, uart_tx}, 32'd1);
                    rx_q.push_back(mon_sh);
                    rx_t.push_back(mon_t0);
                    mon_act = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[0] is the first level on the wire (start bit)
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen;
        logic       busy_last;
        logic       rdy;
        int         acc;
        int         idx;
        int         guard;
        int         bad;
        logic [7:0] wr_bytes[40];
        logic [7:0] lb_bytes[3];

        vecs[0] = '{data: 8'h53, line: 10'b1010100110};
        vecs[1] = '{data: 8'h00, line: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, line: 10'b1111111110};
        vecs[3] = '{data: 8'h41, line: 10'b1010000010};
        vecs[4] = '{data: 8'hA5, line: 10'b1101001010};

        // reset state
        repeat (2) step();
        check("rst_tx",    {31'd0, uart_tx},    32'd1);
        check("rst_level", {27'd0, fifo_level}, 32'd0);
        check("rst_ready", {31'd0, send_ready}, 32'd1);
        check("rst_busy",  {31'd0, uart_busy},  32'd0);
        reset = 1'b1;
        repeat (2) step();

        // single frames from idle, exact per-bit hold times
        for (int v = 0; v < 5; v++) begin
            rx_q.delete();
            rx_t.delete();
            send_data  = vecs[v].data;
            send_valid = 1'b1;
            step();
            send_valid = 1'b0;
            check($sformatf("v%0d_push_level", v), {27'd0, fifo_level}, 32'd1);
            check($sformatf("v%0d_no_bypass", v),  {31'd0, uart_tx},    32'd1);
            step();
            check($sformatf("v%0d_pop_level", v),  {27'd0, fifo_level}, 32'd0);
            check($sformatf("v%0d_busy", v),       {31'd0, uart_busy},  32'd1);
            busy_last = 1'b0;
            for (int b = 0; b < 10; b++) begin
                seen = vecs[v].line[b];
                for (int c = 0; c < CPB; c++) begin
                    if (uart_tx !== vecs[v].line[b]) seen = uart_tx;
                    busy_last = uart_busy;
                    step();
                end
                check($sformatf("v%0d_bit%0d", v, b), {31'd0, seen}, {31'd0, vecs[v].line[b]});
            end
            check($sformatf("v%0d_busy_to_end", v), {31'd0, busy_last}, 32'd1);
            check($sformatf("v%0d_idle_after", v),  {31'd0, uart_busy}, 32'd0);
            check($sformatf("v%0d_tx_idle", v),     {31'd0, uart_tx},   32'd1);
            check($sformatf("v%0d_rx_count", v),    rx_q.size(),        32'd1);
            if (rx_q.size() == 1)
                check($sformatf("v%0d_rx_byte", v), {24'd0, rx_q[0]}, {24'd0, vecs[v].data});
        end

        // back-to-back burst
        rx_q.delete();
        rx_t.delete();
        lb_bytes[0] = 8'h00;
        lb_bytes[1] = 8'hFF;
        lb_bytes[2] = 8'h41;
        for (int i = 0; i < 3; i++) begin
            send_data  = lb_bytes[i];
            send_valid = 1'b1;
            step();
        end
        send_valid = 1'b0;
        wait_idle(4 * FRAME, "burst_drain");
        check("burst_count", rx_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            check($sformatf("burst_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, lb_bytes[i]});
            if (i > 0) check($sformatf("burst_gap%0d", i), rx_t[i] - rx_t[i-1], FRAME);
        end
        check("burst_line_idle", {31'd0, uart_tx}, 32'd1);

        // fill from reset release, then push while full
        reset = 1'b0;
        repeat (2) step();
        rx_q.delete();
        rx_t.delete();
        send_data  = 8'h00;
        send_valid = 1'b1;
        reset = 1'b1;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            rdy = send_ready;
            step();
            if (rdy) begin
                acc++;
                send_data = send_data + 8'd1;
            end
        end
        check("fill_accepted", acc, 32'd17);
        check("fill_ready",    {31'd0, send_ready}, 32'd0);
        check("fill_level",    {27'd0, fifo_level}, 32'd16);
        send_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("full_push_level%0d", i), {27'd0, fifo_level}, 32'd16);
        end
        send_valid = 1'b0;
        wait_idle(18 * FRAME, "fill_drain");
        check("fill_rx_count", rx_q.size(), 32'd17);
        bad = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i] !== 8'(i)) bad++;
            if (i > 0 && rx_t[i] - rx_t[i-1] != FRAME) bad++;
        end
        check("fill_order_and_gaps", bad, 32'd0);

        // pointer wrap: 40 bytes honouring send_ready
        rx_q.delete();
        rx_t.delete();
        for (int i = 0; i < 40; i++) wr_bytes[i] = 8'(i * 37 + 5);
        idx = 0;
        guard = 0;
        while (idx < 40 && guard < 5000) begin
            send_data  = wr_bytes[idx];
            send_valid = 1'b1;
            rdy = send_ready;
            step();
            if (rdy) idx++;
            guard++;
        end
        send_valid = 1'b0;
        check("wrap_pushed", idx, 32'd40);
        wait_idle(42 * FRAME, "wrap_drain");
        check("wrap_rx_count", rx_q.size(), 32'd40);
        bad = 0;
        for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
            if (rx_q[i] !== wr_bytes[i]) begin
                bad++;
                $display("FAIL wrap_byte%0d: got %0h expected %0h", i, rx_q[i], wr_bytes[i]);
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;

        // reset during DATA bit 3 with 5 bytes queued
        rx_q.delete();
        rx_t.delete();
        for (int i = 0; i < 6; i++) begin
            send_data  = 8'h60 + 8'(i);
            send_valid = 1'b1;
            step();
        end
        send_valid = 1'b0;
        check("mid_level_before", {27'd0, fifo_level}, 32'd5);
        repeat (22) step();
        #2;
        check("mid_bit3_level", {31'd0, uart_tx}, 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_tx",    {31'd0, uart_tx},    32'd1);
        check("mid_rst_level", {27'd0, fifo_level}, 32'd0);
        check("mid_rst_busy",  {31'd0, uart_busy},  32'd0);
        check("mid_rst_ready", {31'd0, send_ready}, 32'd1);
        #20;
        @(posedge clock);
        #1;
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (uart_tx !== 1'b1 || uart_busy !== 1'b0) bad++;
            step();
        end
        check("mid_line_stays_idle", bad, 32'd0);
        check("mid_rx_none", rx_q.size(), 32'd0);
        send_data  = 8'h3C;
        send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        wait_idle(2 * FRAME, "mid_new_drain");
        check("mid_new_count", rx_q.size(), 32'd1);
        if (rx_q.size() >= 1) check("mid_new_byte", {24'd0, rx_q[0]}, 32'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_send_fifo.md
Name: uart_send_fifo

Overview:
Buffered UART transmitter, 8N1, LSB first. It is the transmit-side counterpart of uart_recv and uses the same bit timing: CLKS_PER_BIT clocks per bit, 868 at the default.
- Core logic pushes bytes into an internal FIFO with a valid/ready handshake.
- The block serializes the FIFO contents onto the TX line, back-to-back, with no idle gap while data remains.
- It sits between the brainfxck core's output ('.' instruction) and the board UART TX pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (legal range 2 and up).
FIFO_DEPTH, 16, FIFO entries; must be a power of two.
ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
send_data  input  8  byte to enqueue.
send_valid  input  1  send_data is valid this cycle.
send_ready  output  1  FIFO can accept a byte. Combinational: equals fifo_level != FIFO_DEPTH.
uart_tx  output  1  serial line; registered; idles high.
uart_busy  output  1  high when state != IDLE or fifo_level != 0. Combinational from registers.
fifo_level  output  ADDR_W+1  number of bytes currently queued (0..FIFO_DEPTH).

Behaviour:
Reset (reset=0, asynchronous):
- uart_tx=1, state=IDLE, fifo_level=0, read/write pointers=0, bit timer=0, bit index=0.
- Therefore send_ready=1 and uart_busy=0.
- Reset mid-frame: the line returns high immediately and the frame is truncated. Queued bytes are discarded. No partial byte is resumed after release.

Push:
- On an edge with send_valid & send_ready, write send_data at the write pointer and increment the pointer. The pointer wraps modulo FIFO_DEPTH.
- When full, send_valid is ignored and data is not stored. No error flag.

Pop:
- The FSM pops the head entry, loads it into the shift register and increments the read pointer (wraps).
- fifo_level change per edge: +1 on push only, -1 on pop only, unchanged on push and pop together.
- A push into an empty FIFO is not bypassed. The FSM sees the byte on the following edge.

FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If fifo_level != 0 at the edge: pop, uart_tx<=0, timer<=0, go to START.
  - Otherwise uart_tx stays 1.
- START: when timer==CLKS_PER_BIT-1, timer<=0, bit index<=0, uart_tx<=shift[0], go to DATA. Otherwise timer++.
- DATA: at the end of each bit period:
  - If bit index < 7: shift right, bit index++, uart_tx<=next bit.
  - After bit 7: uart_tx<=1, go to STOP.
- STOP: at the end of the bit period:
  - If fifo_level != 0: pop in the same edge, uart_tx<=0, go to START. Back-to-back frames, no idle gap.
  - Otherwise go to IDLE with uart_tx=1.

Timing:
- Every bit level holds for exactly CLKS_PER_BIT cycles. One frame is 10*CLKS_PER_BIT cycles.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE pops at edge N+1. uart_tx falls immediately after edge N+1.
- Timer width: clog2(CLKS_PER_BIT) bits; the timer never exceeds CLKS_PER_BIT-1.

Test Plan:
1. Reset release, then push 0x53 once (CLKS_PER_BIT=868) -> uart_tx falls 1 cycle after the push edge. Line sequence, each level exactly 868 cycles: 0, then 1,1,0,0,1,0,1,0, then stop 1. uart_busy drops 8680 cycles after the fall. fifo_level returns to 0 at the pop edge.
2. Loopback: connect uart_tx to uart_recv rx with the same CLKS_PER_BIT and push 0x00, 0xFF, 0x41 -> receiver reports the same three bytes in order with uart_okay pulses. Line idles high between bursts.
3. Fill (CLKS_PER_BIT=8), send_valid held high from reset release with incrementing data -> exactly 17 bytes accepted: 1 popped at edge 1, then 16 queued. send_ready=0 and fifo_level=16 afterwards. All 17 bytes appear on the line in order with no gaps: stop bit immediately followed by start bit.
4. Pointer wrap: push 40 bytes while honouring send_ready (CLKS_PER_BIT=4) -> serial output matches the push order across the wrap. No byte is lost or duplicated.
5. Reset mid-frame: assert reset during DATA bit 3 with 5 bytes queued -> uart_tx=1, fifo_level=0, uart_busy=0 in the same cycle (asynchronous). After release the line stays high until a new push.
6. Push while full (send_ready=0, send_valid=1, data 0xEE) -> fifo_level unchanged and 0xEE never transmitted.
